// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizing constants, index and count types, and the
// per-entry record. The status bits are kept in their own struct so the retire selector only
// sees what it decides on.
package reorder_buffer_pkg;

    localparam int unsigned NUM_ROB_ENTS = 64;
    localparam int unsigned DISP_WIDTH   = 2;
    localparam int unsigned RETIRE_WIDTH = 4;
    localparam int unsigned NUM_FUS      = 4;
    localparam int unsigned NUM_PREGS    = 128;
    localparam int unsigned NUM_AREGS    = 32;

    localparam int unsigned PW  = $clog2(NUM_PREGS);
    localparam int unsigned AW  = $clog2(NUM_AREGS);
    localparam int unsigned RIW = $clog2(NUM_ROB_ENTS);
    // Widths of per-cycle retire count, retire lane index and allocate count.
    localparam int unsigned RCW = $clog2(RETIRE_WIDTH + 1);
    localparam int unsigned RLW = $clog2(RETIRE_WIDTH);
    localparam int unsigned DCW = $clog2(DISP_WIDTH + 1);

    typedef logic [RIW-1:0] rob_idx_t;
    typedef logic [RIW:0]   rob_cnt_t;

    typedef struct packed {
        logic valid;
        logic done;
        logic exception;
        logic br_mispred;
    } rob_status_t;

    typedef struct packed {
        rob_status_t    st;
        logic [AW-1:0]  dst_reg;
        logic [PW-1:0]  dst_preg;
        logic [31:0]    pc;
    } rob_entry_t;

    // Number of set bits in a dispatch lane mask.
    function automatic logic [DCW-1:0] lane_popcount(input logic [DISP_WIDTH-1:0] mask);
        logic [DCW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DISP_WIDTH); i++) begin
            if (mask[i]) begin
                n = n + DCW'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Retire lane selection for the reorder buffer (purely combinational).
// Ports:
//   head_st_i    - status of the RETIRE_WIDTH entries starting at head (lane 0 = head)
//   ret_mask_o   - contiguous-from-lane-0 mask of lanes retiring this cycle
//   ret_cnt_o    - number of retiring lanes
//   flush_o      - a retiring lane carries an exception or branch mispredict
//   flush_lane_o - lane that triggers the flush (last retiring lane when flush_o is set)
import reorder_buffer_pkg::*;

module rob_retire_select (
    input  rob_status_t [RETIRE_WIDTH-1:0] head_st_i,
    output logic [RETIRE_WIDTH-1:0]        ret_mask_o,
    output logic [RCW-1:0]                 ret_cnt_o,
    output logic                           flush_o,
    output logic [RLW-1:0]                 flush_lane_o
);

    logic stop;

    always_comb begin
        ret_mask_o   = '0;
        ret_cnt_o    = '0;
        flush_o      = 1'b0;
        flush_lane_o = '0;
        stop         = 1'b0;
        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            if (!stop && head_st_i[k].valid && head_st_i[k].done) begin
                ret_mask_o[k] = 1'b1;
                ret_cnt_o     = ret_cnt_o + RCW'(1);
                // A faulting entry still retires but nothing younger may follow it.
                if (head_st_i[k].exception || head_st_i[k].br_mispred) begin
                    flush_o      = 1'b1;
                    flush_lane_o = RLW'(k);
                    stop         = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit stage. Allocates up to DISP_WIDTH entries per cycle at the tail, marks them
// done from NUM_FUS completion ports, and retires up to RETIRE_WIDTH done entries per cycle
// from the head. A retiring exception/mispredict raises flush and empties the buffer.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   alloc_valid/_dst_reg/
//     _dst_preg/_pc            - per-lane allocation request and payload
//   alloc_ready                - at least DISP_WIDTH entries free
//   alloc_rob_idx              - index assigned to each lane (combinational from tail)
//   cmpl_valid/_rob_idx/
//     _exception/_br_mispred   - per-FU completion reports
//   ret_valid/_dst_reg/_dst_preg - retiring lanes, contiguous from lane 0
//   flush, flush_pc            - flush pulse and PC of the faulting instruction
//   rob_count                  - occupied entries
import reorder_buffer_pkg::*;

module reorder_buffer (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DISP_WIDTH-1:0]        alloc_valid,
    input  logic [DISP_WIDTH*AW-1:0]     alloc_dst_reg,
    input  logic [DISP_WIDTH*PW-1:0]     alloc_dst_preg,
    input  logic [DISP_WIDTH*32-1:0]     alloc_pc,
    output logic                         alloc_ready,
    output logic [DISP_WIDTH*RIW-1:0]    alloc_rob_idx,
    input  logic [NUM_FUS-1:0]           cmpl_valid,
    input  logic [NUM_FUS*RIW-1:0]       cmpl_rob_idx,
    input  logic [NUM_FUS-1:0]           cmpl_exception,
    input  logic [NUM_FUS-1:0]           cmpl_br_mispred,
    output logic [RETIRE_WIDTH-1:0]      ret_valid,
    output logic [RETIRE_WIDTH*AW-1:0]   ret_dst_reg,
    output logic [RETIRE_WIDTH*PW-1:0]   ret_dst_preg,
    output logic                         flush,
    output logic [31:0]                  flush_pc,
    output logic [RIW:0]                 rob_count
);

    rob_entry_t entries_q [NUM_ROB_ENTS];
    rob_entry_t entries_d [NUM_ROB_ENTS];
    rob_idx_t   head_q, head_d;
    rob_idx_t   tail_q, tail_d;
    rob_cnt_t   count_q, count_d;

    rob_idx_t   alloc_idx [DISP_WIDTH];
    logic [DCW-1:0] alloc_cnt;
    logic       alloc_fire;

    rob_idx_t   ret_idx [RETIRE_WIDTH];
    rob_status_t [RETIRE_WIDTH-1:0] head_st;
    logic [RETIRE_WIDTH-1:0] ret_mask;
    logic [RCW-1:0] ret_cnt;
    logic       ret_flush;
    logic [RLW-1:0] flush_lane;

    // ---------------------------------------------------------------- allocation
    // Each lane takes tail plus the number of valid lanes below it, so sparse masks pack densely.
    always_comb begin
        for (int i = 0; i < int'(DISP_WIDTH); i++) begin
            alloc_idx[i] = tail_q + rob_idx_t'(lane_popcount(alloc_valid & DISP_WIDTH'((1 << i) - 1)));
        end
    end

    assign alloc_cnt   = lane_popcount(alloc_valid);
    assign alloc_ready = count_q <= rob_cnt_t'(NUM_ROB_ENTS - DISP_WIDTH);
    // Dispatch in the flush cycle belongs to the squashed path and is dropped.
    assign alloc_fire  = alloc_ready && !ret_flush;

    for (genvar i = 0; i < int'(DISP_WIDTH); i++) begin : g_alloc_idx
        assign alloc_rob_idx[i*RIW +: RIW] = alloc_idx[i];
    end

    // ---------------------------------------------------------------- retire
    for (genvar k = 0; k < int'(RETIRE_WIDTH); k++) begin : g_ret
        assign ret_idx[k] = head_q + rob_idx_t'(k);
        assign head_st[k] = entries_q[ret_idx[k]].st;
        assign ret_dst_reg[k*AW +: AW]  = ret_mask[k] ? entries_q[ret_idx[k]].dst_reg  : '0;
        assign ret_dst_preg[k*PW +: PW] = ret_mask[k] ? entries_q[ret_idx[k]].dst_preg : '0;
    end

    rob_retire_select u_retire_select (
        .head_st_i    (head_st),
        .ret_mask_o   (ret_mask),
        .ret_cnt_o    (ret_cnt),
        .flush_o      (ret_flush),
        .flush_lane_o (flush_lane)
    );

    assign ret_valid = ret_mask;
    assign flush     = ret_flush;
    assign flush_pc  = ret_flush ? entries_q[ret_idx[flush_lane]].pc : 32'h0;
    assign rob_count = count_q;

    // ---------------------------------------------------------------- next state
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q + rob_idx_t'(ret_cnt);
        tail_d    = tail_q;
        count_d   = count_q - rob_cnt_t'(ret_cnt);

        // Completion is judged on the registered valid bit, so a report racing the allocation
        // of the same slot is discarded.
        for (int f = 0; f < int'(NUM_FUS); f++) begin
            if (cmpl_valid[f] && entries_q[cmpl_rob_idx[f*RIW +: RIW]].st.valid) begin
                entries_d[cmpl_rob_idx[f*RIW +: RIW]].st.done       = 1'b1;
                entries_d[cmpl_rob_idx[f*RIW +: RIW]].st.exception  =
                    entries_q[cmpl_rob_idx[f*RIW +: RIW]].st.exception | cmpl_exception[f];
                entries_d[cmpl_rob_idx[f*RIW +: RIW]].st.br_mispred =
                    entries_q[cmpl_rob_idx[f*RIW +: RIW]].st.br_mispred | cmpl_br_mispred[f];
            end
        end

        for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
            if (ret_mask[k]) begin
                entries_d[ret_idx[k]].st = '0;
            end
        end

        if (alloc_fire) begin
            for (int i = 0; i < int'(DISP_WIDTH); i++) begin
                if (alloc_valid[i]) begin
                    entries_d[alloc_idx[i]].st       = '{valid: 1'b1, done: 1'b0,
                                                         exception: 1'b0, br_mispred: 1'b0};
                    entries_d[alloc_idx[i]].dst_reg  = alloc_dst_reg[i*AW +: AW];
                    entries_d[alloc_idx[i]].dst_preg = alloc_dst_preg[i*PW +: PW];
                    entries_d[alloc_idx[i]].pc       = alloc_pc[i*32 +: 32];
                end
            end
            tail_d  = tail_q + rob_idx_t'(alloc_cnt);
            count_d = count_d + rob_cnt_t'(alloc_cnt);
        end

        if (ret_flush) begin
            for (int e = 0; e < int'(NUM_ROB_ENTS); e++) begin
                entries_d[e] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < int'(NUM_ROB_ENTS); e++) begin
                entries_q[e] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Two FUs completing the same entry in one cycle means an upstream scheduling bug.
    for (genvar a = 0; a < int'(NUM_FUS); a++) begin : g_chk_a
        for (genvar b = a + 1; b < int'(NUM_FUS); b++) begin : g_chk_b
            assert property (@(posedge clk) disable iff (rst)
                !(cmpl_valid[a] && cmpl_valid[b] &&
                  cmpl_rob_idx[a*RIW +: RIW] == cmpl_rob_idx[b*RIW +: RIW]));
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with hand-computed expected values.
import reorder_buffer_pkg::*;

module tb_reorder_buffer;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [DISP_WIDTH-1:0]        alloc_valid;
    logic [DISP_WIDTH*AW-1:0]     alloc_dst_reg;
    logic [DISP_WIDTH*PW-1:0]     alloc_dst_preg;
    logic [DISP_WIDTH*32-1:0]     alloc_pc;
    logic                         alloc_ready;
    logic [DISP_WIDTH*RIW-1:0]    alloc_rob_idx;
    logic [NUM_FUS-1:0]           cmpl_valid;
    logic [NUM_FUS*RIW-1:0]       cmpl_rob_idx;
    logic [NUM_FUS-1:0]           cmpl_exception;
    logic [NUM_FUS-1:0]           cmpl_br_mispred;
    logic [RETIRE_WIDTH-1:0]      ret_valid;
    logic [RETIRE_WIDTH*AW-1:0]   ret_dst_reg;
    logic [RETIRE_WIDTH*PW-1:0]   ret_dst_preg;
    logic                         flush;
    logic [31:0]                  flush_pc;
    logic [RIW:0]                 rob_count;

    int n_tests = 0;
    int n_fail  = 0;

    reorder_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_dst_reg   (alloc_dst_reg),
        .alloc_dst_preg  (alloc_dst_preg),
        .alloc_pc        (alloc_pc),
        .alloc_ready     (alloc_ready),
        .alloc_rob_idx   (alloc_rob_idx),
        .cmpl_valid      (cmpl_valid),
        .cmpl_rob_idx    (cmpl_rob_idx),
        .cmpl_exception  (cmpl_exception),
        .cmpl_br_mispred (cmpl_br_mispred),
        .ret_valid       (ret_valid),
        .ret_dst_reg     (ret_dst_reg),
        .ret_dst_preg    (ret_dst_preg),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .rob_count       (rob_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        alloc_valid     = '0;
        alloc_dst_reg   = '0;
        alloc_dst_preg  = '0;
        alloc_pc        = '0;
        cmpl_valid      = '0;
        cmpl_rob_idx    = '0;
        cmpl_exception  = '0;
        cmpl_br_mispred = '0;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_alloc(input int lane, input int preg, input logic [31:0] pc);
        alloc_valid[lane]               = 1'b1;
        alloc_dst_preg[lane*PW +: PW]   = PW'(preg);
        alloc_dst_reg[lane*AW +: AW]    = AW'(preg);
        alloc_pc[lane*32 +: 32]         = pc;
    endtask

    task automatic do_cmpl(input int fu, input int idx, input logic exc, input logic mis);
        cmpl_valid[fu]                = 1'b1;
        cmpl_rob_idx[fu*RIW +: RIW]   = RIW'(idx);
        cmpl_exception[fu]            = exc;
        cmpl_br_mispred[fu]           = mis;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ready", alloc_ready, 1);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_count", rob_count, 0);

        // Two allocations, then complete both
        do_alloc(0, 10, 32'h100);
        do_alloc(1, 11, 32'h104);
        #1;
        check("t1_alloc_idx", alloc_rob_idx, {6'd1, 6'd0});
        step();
        check("t1_count", rob_count, 2);
        do_cmpl(0, 0, 1'b0, 1'b0);
        do_cmpl(1, 1, 1'b0, 1'b0);
        #1;
        check("t1_no_same_cycle_retire", ret_valid, 0);
        step();
        check("t1_ret_valid", ret_valid, 4'b0011);
        check("t1_flush", flush, 0);
        check("t1_ret_preg", ret_dst_preg, {7'd0, 7'd0, 7'd11, 7'd10});
        step();
        check("t1_count_drained", rob_count, 0);

        // Head blocked until entry 2 completes (head = tail = 2)
        do_alloc(0, 2, 32'h108);
        do_alloc(1, 3, 32'h10c);
        step();
        do_alloc(0, 4, 32'h110);
        do_alloc(1, 5, 32'h114);
        step();
        do_cmpl(0, 3, 1'b0, 1'b0);
        do_cmpl(1, 4, 1'b0, 1'b0);
        do_cmpl(2, 5, 1'b0, 1'b0);
        step();
        check("t2_head_blocked", ret_valid, 4'b0000);
        do_cmpl(3, 2, 1'b0, 1'b0);
        step();
        check("t2_ret_all", ret_valid, 4'b1111);
        check("t2_ret_reg", ret_dst_reg, {5'd5, 5'd4, 5'd3, 5'd2});
        step();
        check("t2_count", rob_count, 0);

        // Sparse mask: only lane 1 valid, takes tail (6)
        do_alloc(1, 6, 32'h118);
        #1;
        check("t2_sparse_idx", alloc_rob_idx, {6'd6, 6'd6});
        step();
        check("t2_sparse_count", rob_count, 1);
        do_cmpl(2, 6, 1'b0, 1'b0);
        step();
        check("t2_sparse_ret", ret_valid, 4'b0001);
        check("t2_sparse_preg", ret_dst_preg, {7'd0, 7'd0, 7'd0, 7'd6});
        step();

        // Fill to capacity
        do_reset();
        for (int i = 0; i < 31; i++) begin
            do_alloc(0, 2 * i, 32'h1000 + 32'(8 * i));
            do_alloc(1, 2 * i + 1, 32'h1004 + 32'(8 * i));
            step();
        end
        check("t3_count62", rob_count, 62);
        check("t3_ready62", alloc_ready, 1);
        do_alloc(0, 62, 32'h10f8);
        do_alloc(1, 63, 32'h10fc);
        step();
        check("t3_count64", rob_count, 64);
        check("t3_ready64", alloc_ready, 0);
        do_alloc(0, 99, 32'hdead);
        do_alloc(1, 98, 32'hbeef);
        step();
        check("t3_ignored_count", rob_count, 64);
        alloc_valid = 2'b11;
        #1;
        check("t3_tail_unchanged", alloc_rob_idx, {6'd1, 6'd0});
        clear_inputs();
        do_cmpl(0, 0, 1'b0, 1'b0);
        step();
        step();
        check("t3_count63", rob_count, 63);
        check("t3_ready63", alloc_ready, 0);

        // Drain 1..61 so head lands on 62
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 4; f++) begin
                if (1 + 4 * c + f <= 61) do_cmpl(f, 1 + 4 * c + f, 1'b0, 1'b0);
            end
            step();
        end
        for (int w = 0; w < 5; w++) step();
        check("t4_count2", rob_count, 2);

        // Wrap: entries 62, 63, 0, 1 retire together
        do_alloc(0, 0, 32'h2000);
        do_alloc(1, 1, 32'h2004);
        #1;
        check("t4_alloc_wrap_idx", alloc_rob_idx, {6'd1, 6'd0});
        step();
        do_cmpl(0, 62, 1'b0, 1'b0);
        do_cmpl(1, 63, 1'b0, 1'b0);
        do_cmpl(2, 0, 1'b0, 1'b0);
        do_cmpl(3, 1, 1'b0, 1'b0);
        step();
        check("t4_wrap_ret", ret_valid, 4'b1111);
        check("t4_wrap_preg", ret_dst_preg, {7'd1, 7'd0, 7'd63, 7'd62});
        step();
        check("t4_wrap_count", rob_count, 0);
        do_alloc(0, 2, 32'h2008);
        step();
        do_cmpl(0, 2, 1'b0, 1'b0);
        step();
        check("t4_head_at_2", ret_valid, 4'b0001);
        step();

        // Mispredict flush on lane 1
        do_reset();
        do_alloc(0, 20, 32'h200);
        do_alloc(1, 21, 32'h204);
        step();
        do_alloc(0, 22, 32'h208);
        do_alloc(1, 23, 32'h20c);
        step();
        do_cmpl(0, 0, 1'b0, 1'b0);
        do_cmpl(1, 1, 1'b0, 1'b1);
        do_cmpl(2, 2, 1'b0, 1'b0);
        do_cmpl(3, 3, 1'b0, 1'b0);
        step();
        check("t5_flush_ret", ret_valid, 4'b0011);
        check("t5_flush", flush, 1);
        check("t5_flush_pc", flush_pc, 32'h204);
        do_alloc(0, 30, 32'h300);
        do_alloc(1, 31, 32'h304);
        step();
        check("t5_post_count", rob_count, 0);
        check("t5_post_flush", flush, 0);
        check("t5_post_ret", ret_valid, 0);
        alloc_valid = 2'b11;
        #1;
        check("t5_tail_reset", alloc_rob_idx, {6'd1, 6'd0});
        clear_inputs();

        // Exception on the head lane
        do_alloc(0, 40, 32'h400);
        do_alloc(1, 41, 32'h404);
        step();
        do_cmpl(0, 0, 1'b1, 1'b0);
        do_cmpl(1, 1, 1'b0, 1'b0);
        step();
        check("t5_exc_ret", ret_valid, 4'b0001);
        check("t5_exc_pc", flush_pc, 32'h400);
        step();
        check("t5_exc_count", rob_count, 0);

        // Completion to an invalid entry is ignored
        do_cmpl(0, 0, 1'b0, 1'b0);
        step();
        do_alloc(0, 50, 32'h500);
        step();
        check("t5_stale_cmpl", ret_valid, 0);
        check("t5_stale_count", rob_count, 1);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_alloc(0, 2 * i, 32'h600 + 32'(8 * i));
            do_alloc(1, 2 * i + 1, 32'h604 + 32'(8 * i));
            step();
        end
        check("t6_count10", rob_count, 10);
        do_cmpl(0, 0, 1'b0, 1'b0);
        do_cmpl(1, 1, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_count", rob_count, 0);
        check("t6_ret", ret_valid, 0);
        check("t6_ready", alloc_ready, 1);
        step();
        check("t6_no_late_ret", ret_valid, 0);
        check("t6_no_flush", flush, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
